// File: rtl/mem_port_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared definitions for the byte-wide RAM port arbiter: FSM state encoding,
// mem_len encodings and the length-to-byte-count decode.
// ----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_IF,
        ST_RD_MEM,
        ST_WR_MEM,
        ST_DONE
    } state_t;

    localparam logic [1:0] LEN_B = 2'd0;
    localparam logic [1:0] LEN_H = 2'd1;
    localparam logic [1:0] LEN_W = 2'd2;

    // Instruction fetches are always a full word.
    localparam logic [2:0] IF_BYTES = 3'd4;

    // Illegal encoding 3 falls through to a word transfer.
    function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
        case (len)
            LEN_B:   return 3'd1;
            LEN_H:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one byte-wide RAM port between instruction fetch (IF) and the MEM
// stage. 1/2/4-byte transfers are serialised into per-byte RAM cycles and
// words are assembled/split little-endian. Stall outputs hold the requesting
// pipeline stage while its transfer is outstanding.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-low reset
//   flush               cancels an in-flight or pending IF transfer
//   if_req/if_addr      IF 4-byte read request and byte address
//   if_data/if_done     assembled instruction, one-cycle completion pulse
//   mem_req/mem_we      MEM load/store request (we=1 store)
//   mem_len/mem_addr    0=byte 1=half 2/3=word, byte address
//   mem_wdata           store data (low bytes used)
//   mem_rdata/mem_done  zero-extended load data, one-cycle completion pulse
//   ram_addr/ram_wr     registered RAM byte address and write strobe
//   ram_dout/ram_din    RAM write byte / read byte (din valid one cycle
//                       after its address is presented)
//   stall_if/stall_mem  request pending and not completing this cycle
// ----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_data,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din,
    output logic              stall_if,
    output logic              stall_mem
);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        nbytes_q, nbytes_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       asm_q, asm_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_wr_q, ram_wr_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;
    logic              if_done_q, if_done_d;
    logic              mem_done_q, mem_done_d;

    // cnt counts edges spent in a transfer state. At edge with cnt=c the
    // byte addressed c cycles earlier (lane c-1) is on ram_din, and the
    // address/write for byte c+1 is issued. Reads and writes share this
    // timing so both complete N+1 edges after accept.
    logic [2:0]  cnt_nxt;
    logic [1:0]  cap_lane;
    logic [1:0]  wr_lane;
    logic [31:0] asm_merged;
    logic        is_read;

    assign cnt_nxt  = cnt_q + 3'd1;
    assign cap_lane = 2'(cnt_q - 3'd1);
    assign wr_lane  = 2'(cnt_nxt);
    assign is_read  = (state_q == ST_RD_IF) || (state_q == ST_RD_MEM);

    always_comb begin
        asm_merged = asm_q;
        asm_merged[{cap_lane, 3'b000} +: 8] = ram_din;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        nbytes_d    = nbytes_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        asm_d       = asm_q;
        ram_addr_d  = ram_addr_q;
        ram_wr_d    = 1'b0;
        ram_dout_d  = ram_dout_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // MEM first: it carries the older instruction.
                if (mem_req) begin
                    base_d     = mem_addr;
                    nbytes_d   = len_to_bytes(mem_len);
                    wdata_d    = mem_wdata;
                    asm_d      = '0;
                    cnt_d      = '0;
                    ram_addr_d = mem_addr;
                    if (mem_we) begin
                        ram_wr_d   = 1'b1;
                        ram_dout_d = mem_wdata[7:0];
                        state_d    = ST_WR_MEM;
                    end else begin
                        state_d    = ST_RD_MEM;
                    end
                end else if (if_req && !flush) begin
                    base_d     = if_addr;
                    nbytes_d   = IF_BYTES;
                    asm_d      = '0;
                    cnt_d      = '0;
                    ram_addr_d = if_addr;
                    state_d    = ST_RD_IF;
                end
            end

            ST_RD_IF, ST_RD_MEM, ST_WR_MEM: begin
                if (state_q == ST_RD_IF && flush) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_nxt;
                    if (is_read && cnt_q != 3'd0) begin
                        asm_d = asm_merged;
                    end
                    if (cnt_nxt < nbytes_q) begin
                        ram_addr_d = base_q + ADDR_W'(cnt_nxt);
                        if (state_q == ST_WR_MEM) begin
                            ram_wr_d   = 1'b1;
                            ram_dout_d = wdata_q[{wr_lane, 3'b000} +: 8];
                        end
                    end
                    if (cnt_q == nbytes_q) begin
                        state_d = ST_DONE;
                        case (state_q)
                            ST_RD_IF: begin
                                if_data_d = asm_merged;
                                if_done_d = 1'b1;
                            end
                            ST_RD_MEM: begin
                                mem_rdata_d = asm_merged;
                                mem_done_d  = 1'b1;
                            end
                            default: begin
                                mem_done_d = 1'b1;
                            end
                        endcase
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            nbytes_q    <= '0;
            base_q      <= '0;
            wdata_q     <= '0;
            asm_q       <= '0;
            ram_addr_q  <= '0;
            ram_wr_q    <= 1'b0;
            ram_dout_q  <= '0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            nbytes_q    <= nbytes_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            asm_q       <= asm_d;
            ram_addr_q  <= ram_addr_d;
            ram_wr_q    <= ram_wr_d;
            ram_dout_q  <= ram_dout_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_wr    = ram_wr_q;
    assign ram_dout  = ram_dout_q;
    assign if_data   = if_data_q;
    assign mem_rdata = mem_rdata_q;
    assign mem_done  = mem_done_q;

    // A mispredict arriving in the DONE cycle kills the fetch result, so the
    // registered pulse is gated by the live flush.
    assign if_done   = if_done_q && !flush;

    assign stall_if  = if_req && !if_done;
    assign stall_mem = mem_req && !mem_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with a byte RAM model whose read data
// appears one cycle after the address is presented.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush = 1'b0;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic [31:0]       if_data;
    logic              if_done;
    logic              mem_req = 1'b0;
    logic              mem_we = 1'b0;
    logic [1:0]        mem_len = 2'd0;
    logic [ADDR_W-1:0] mem_addr = '0;
    logic [31:0]       mem_wdata = '0;
    logic [31:0]       mem_rdata;
    logic              mem_done;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wr;
    logic [7:0]        ram_dout;
    logic [7:0]        ram_din;
    logic              stall_if;
    logic              stall_mem;

    int checks = 0;
    int fails  = 0;

    logic [7:0]  ram [0:65535];
    logic [31:0] wlog_a [$];
    logic [7:0]  wlog_d [$];
    logic [7:0]  sw_b [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

    mem_port_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_data   (if_data),
        .if_done   (if_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_len   (mem_len),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .ram_addr  (ram_addr),
        .ram_wr    (ram_wr),
        .ram_dout  (ram_dout),
        .ram_din   (ram_din),
        .stall_if  (stall_if),
        .stall_mem (stall_mem)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wr === 1'b1) begin
            ram[ram_addr[15:0]] <= ram_dout;
            wlog_a.push_back(ram_addr);
            wlog_d.push_back(ram_dout);
        end
        ram_din <= ram[ram_addr[15:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ram_addr"},  ram_addr, 32'h0);
        check({tag, "_ram_wr"},    {31'b0, ram_wr}, 32'h0);
        check({tag, "_ram_dout"},  {24'b0, ram_dout}, 32'h0);
        check({tag, "_if_data"},   if_data, 32'h0);
        check({tag, "_mem_rdata"}, mem_rdata, 32'h0);
        check({tag, "_if_done"},   {31'b0, if_done}, 32'h0);
        check({tag, "_mem_done"},  {31'b0, mem_done}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[16'h0100] = 8'h13; ram[16'h0101] = 8'h05;
        ram[16'h0102] = 8'h00; ram[16'h0103] = 8'h00;
        ram[16'h0104] = 8'hAA; ram[16'h0105] = 8'hBB;
        ram[16'h0106] = 8'hCC; ram[16'h0107] = 8'hDD;
        ram[16'hFFFF] = 8'h11; ram[16'h0000] = 8'h22;
        ram[16'h3002] = 8'h77;

        // Reset state
        rst = 1'b0;
        tick(); tick();
        check_all_zero("rst");
        check("rst_stall_if",  {31'b0, stall_if},  32'h0);
        check("rst_stall_mem", {31'b0, stall_mem}, 32'h0);
        rst = 1'b1;
        tick();

        // IF word read at 0x100
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        check("if_a0", ram_addr, 32'h100);
        check("if_stall", {31'b0, stall_if}, 32'h1);
        if_addr = 32'h0F00;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("if_addr_seq", ram_addr, 32'h100 + 32'(k));
            check("if_done_early", {31'b0, if_done}, 32'h0);
        end
        tick();
        check("if_done_e4", {31'b0, if_done}, 32'h0);
        tick();
        check("if_done_e5", {31'b0, if_done}, 32'h1);
        check("if_data", if_data, 32'h0000_0513);
        check("if_stall_done", {31'b0, stall_if}, 32'h0);
        check("if_ram_wr", {31'b0, ram_wr}, 32'h0);
        if_req = 1'b0;
        tick();
        check("if_done_pulse", {31'b0, if_done}, 32'h0);

        // SW 0xDEADBEEF at 0x2000
        wlog_a.delete(); wlog_d.delete();
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd2;
        mem_addr = 32'h2000; mem_wdata = 32'hDEAD_BEEF;
        tick();
        check("sw_wr0", {31'b0, ram_wr}, 32'h1);
        check("sw_a0", ram_addr, 32'h2000);
        check("sw_d0", {24'b0, ram_dout}, 32'hEF);
        check("sw_stall", {31'b0, stall_mem}, 32'h1);
        mem_wdata = 32'h0; mem_addr = 32'h5000;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("sw_wr", {31'b0, ram_wr}, 32'h1);
            check("sw_a", ram_addr, 32'h2000 + 32'(k));
            check("sw_d", {24'b0, ram_dout}, {24'b0, sw_b[k]});
            check("sw_done_early", {31'b0, mem_done}, 32'h0);
        end
        tick();
        check("sw_wr_e4", {31'b0, ram_wr}, 32'h0);
        check("sw_done_e4", {31'b0, mem_done}, 32'h0);
        tick();
        check("sw_done_e5", {31'b0, mem_done}, 32'h1);
        check("sw_wr_done", {31'b0, ram_wr}, 32'h0);
        check("sw_stall_done", {31'b0, stall_mem}, 32'h0);
        mem_req = 1'b0; mem_we = 1'b0;
        check("sw_nwrites", 32'(wlog_a.size()), 32'h4);
        for (int k = 0; k < 4; k++) begin
            check("sw_log_a", wlog_a[k], 32'h2000 + 32'(k));
            check("sw_log_d", {24'b0, wlog_d[k]}, {24'b0, sw_b[k]});
        end
        tick();

        // LH 0x2002, then LB 0x2003 requested during DONE
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd1; mem_addr = 32'h2002;
        tick();
        check("lh_a0", ram_addr, 32'h2002);
        check("lh_wr", {31'b0, ram_wr}, 32'h0);
        tick();
        check("lh_a1", ram_addr, 32'h2003);
        check("lh_done_e1", {31'b0, mem_done}, 32'h0);
        tick();
        check("lh_done_e2", {31'b0, mem_done}, 32'h0);
        tick();
        check("lh_done_e3", {31'b0, mem_done}, 32'h1);
        check("lh_rdata", mem_rdata, 32'h0000_DEAD);
        mem_len = 2'd0; mem_addr = 32'h2003;
        tick();
        check("lb_idle_done", {31'b0, mem_done}, 32'h0);
        check("lb_idle_stall", {31'b0, stall_mem}, 32'h1);
        tick();
        check("lb_a0", ram_addr, 32'h2003);
        tick();
        check("lb_done_e1", {31'b0, mem_done}, 32'h0);
        tick();
        check("lb_done_e2", {31'b0, mem_done}, 32'h1);
        check("lb_rdata", mem_rdata, 32'h0000_00DE);
        mem_req = 1'b0;
        tick();

        // Simultaneous requests: MEM first, IF after
        if_req = 1'b1; if_addr = 32'h100;
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd0; mem_addr = 32'h2000;
        tick();
        check("pri_mem_first", ram_addr, 32'h2000);
        check("pri_stall_if0", {31'b0, stall_if}, 32'h1);
        tick();
        check("pri_stall_if1", {31'b0, stall_if}, 32'h1);
        tick();
        check("pri_mem_done", {31'b0, mem_done}, 32'h1);
        check("pri_mem_rdata", mem_rdata, 32'h0000_00EF);
        check("pri_stall_if2", {31'b0, stall_if}, 32'h1);
        check("pri_if_done", {31'b0, if_done}, 32'h0);
        mem_req = 1'b0;
        tick();
        check("pri_idle_addr", ram_addr, 32'h2000);
        check("pri_stall_if3", {31'b0, stall_if}, 32'h1);
        tick();
        check("pri_if_accept", ram_addr, 32'h100);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("pri_if_wait", {31'b0, if_done}, 32'h0);
            check("pri_if_stall", {31'b0, stall_if}, 32'h1);
        end
        tick();
        check("pri_if_done_end", {31'b0, if_done}, 32'h1);
        check("pri_if_data", if_data, 32'h0000_0513);
        if_req = 1'b0;
        tick();

        // Flush on second cycle of an IF read
        if_req = 1'b1; if_addr = 32'h104;
        tick();
        check("fl_a0", ram_addr, 32'h104);
        tick();
        check("fl_a1", ram_addr, 32'h105);
        flush = 1'b1;
        tick();
        check("fl_no_done", {31'b0, if_done}, 32'h0);
        check("fl_if_data_kept", if_data, 32'h0000_0513);
        flush = 1'b0; if_addr = 32'h100;
        tick();
        check("fl_reaccept", ram_addr, 32'h100);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("fl_wait", {31'b0, if_done}, 32'h0);
        end
        tick();
        check("fl_done", {31'b0, if_done}, 32'h1);
        check("fl_data", if_data, 32'h0000_0513);
        flush = 1'b1;
        #1;
        check("fl_done_suppressed", {31'b0, if_done}, 32'h0);
        flush = 1'b0; if_req = 1'b0;
        tick();
        if_req = 1'b1; flush = 1'b1; if_addr = 32'h104;
        tick();
        check("fl_idle_block0", ram_addr, 32'h103);
        tick();
        check("fl_idle_block1", ram_addr, 32'h103);
        if_req = 1'b0; flush = 1'b0;
        tick();

        // Address wrap on LH at all-ones
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd1; mem_addr = 32'hFFFF_FFFF;
        tick();
        check("wrap_a0", ram_addr, 32'hFFFF_FFFF);
        tick();
        check("wrap_a1", ram_addr, 32'h0000_0000);
        tick();
        tick();
        check("wrap_done", {31'b0, mem_done}, 32'h1);
        check("wrap_rdata", mem_rdata, 32'h0000_2211);
        mem_req = 1'b0;
        tick();

        // Reset in the middle of a word store
        wlog_a.delete(); wlog_d.delete();
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd2;
        mem_addr = 32'h3000; mem_wdata = 32'h4433_2211;
        tick();
        check("rsw_a0", ram_addr, 32'h3000);
        check("rsw_d0", {24'b0, ram_dout}, 32'h11);
        tick();
        check("rsw_a1", ram_addr, 32'h3001);
        check("rsw_d1", {24'b0, ram_dout}, 32'h22);
        rst = 1'b0;
        tick();
        check_all_zero("rsw");
        tick();
        check("rsw_done_held", {31'b0, mem_done}, 32'h0);
        rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0;
        tick();
        check("rsw_done_after0", {31'b0, mem_done}, 32'h0);
        tick();
        check("rsw_done_after1", {31'b0, mem_done}, 32'h0);
        check("rsw_wr_after", {31'b0, ram_wr}, 32'h0);
        check("rsw_nwrites", 32'(wlog_a.size()), 32'h2);
        check("rsw_log_a0", wlog_a[0], 32'h3000);
        check("rsw_log_d0", {24'b0, wlog_d[0]}, 32'h11);
        check("rsw_log_a1", wlog_a[1], 32'h3001);
        check("rsw_log_d1", {24'b0, wlog_d[1]}, 32'h22);
        check("rsw_ram_3002", {24'b0, ram[16'h3002]}, 32'h77);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
